// File: rtl/i2s_rx.sv
// I2S receiver: synchronises bclk/lrck/sdata into clk and deserialises MSB-first L/R words.
// Optional macro I2S_RX_FRAME_ERR_EN adds a sticky frame_err output.
module i2s_rx #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned SYNC_N = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bclk,
  input  logic              lrck,
  input  logic              sdata,
  output logic [DATA_W-1:0] l_out,
  output logic [DATA_W-1:0] r_out,
  output logic              valid
`ifdef I2S_RX_FRAME_ERR_EN
  ,
  output logic              frame_err
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_N-1:0] bclk_sync_q, bclk_sync_d;
  logic [SYNC_N-1:0] lrck_sync_q, lrck_sync_d;
  logic [SYNC_N-1:0] sdata_sync_q, sdata_sync_d;
  logic              bclk_prev_q, bclk_prev_d;
  logic              lrck_prev_q, lrck_prev_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              ch_q, ch_d;
  logic              ldone_q, ldone_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] l_q, l_d;
  logic [DATA_W-1:0] r_q, r_d;
  logic              valid_q, valid_d;
`ifdef I2S_RX_FRAME_ERR_EN
  logic              err_q, err_d;
  logic              last_ch_q, last_ch_d;
  logic              last_vld_q, last_vld_d;
`endif

  logic bclk_s, lrck_s, sdata_s;
  logic rise, tr;
  logic start, capture, commit;

  assign bclk_s  = bclk_sync_q[SYNC_N-1];
  assign lrck_s  = lrck_sync_q[SYNC_N-1];
  assign sdata_s = sdata_sync_q[SYNC_N-1];
  assign rise    = bclk_s & ~bclk_prev_q;
  assign tr      = rise & (lrck_s != lrck_prev_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (tr) state_d = SHIFT;
      SHIFT:   if (tr) state_d = COMMIT;
      COMMIT:  state_d = SHIFT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start   = 1'b0;
    capture = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE:    start   = tr;
      SHIFT:   capture = rise;
      COMMIT:  commit  = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    bclk_sync_d  = {bclk_sync_q[SYNC_N-2:0], bclk};
    lrck_sync_d  = {lrck_sync_q[SYNC_N-2:0], lrck};
    sdata_sync_d = {sdata_sync_q[SYNC_N-2:0], sdata};
    bclk_prev_d  = bclk_s;
    lrck_prev_d  = rise ? lrck_s : lrck_prev_q;
    cnt_d        = cnt_q;
    ch_d         = ch_q;
    ldone_d      = ldone_q;
    shift_d      = shift_q;
    l_d          = l_q;
    r_d          = r_q;
    valid_d      = 1'b0;
`ifdef I2S_RX_FRAME_ERR_EN
    err_d        = err_q;
    last_ch_d    = last_ch_q;
    last_vld_d   = last_vld_q;
`endif

    if (start) begin
      cnt_d   = '0;
      ch_d    = lrck_s;
      shift_d = '0;
    end

    // Bits land directly at their MSB-first position, so short slots stay left-aligned.
    if (capture) begin
      for (int unsigned i = 0; i < DATA_W; i++) begin
        if (cnt_q == 5'(DATA_W - 1 - i)) shift_d[i] = sdata_s;
      end
      if (cnt_q != 5'd31) cnt_d = cnt_q + 5'd1;
    end

    if (commit) begin
      if (!ch_q) begin
        l_d     = shift_q;
        ldone_d = 1'b1;
      end else begin
        r_d = shift_q;
        if (ldone_q) begin
          valid_d = 1'b1;
          ldone_d = 1'b0;
        end
      end
`ifdef I2S_RX_FRAME_ERR_EN
      if (cnt_q < 5'(DATA_W)) err_d = 1'b1;
      if (last_vld_q && (last_ch_q == ch_q)) err_d = 1'b1;
      last_ch_d  = ch_q;
      last_vld_d = 1'b1;
`endif
      cnt_d   = '0;
      shift_d = '0;
      ch_d    = lrck_prev_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bclk_sync_q  <= '0;
      lrck_sync_q  <= '0;
      sdata_sync_q <= '0;
      bclk_prev_q  <= 1'b0;
      lrck_prev_q  <= 1'b0;
      cnt_q        <= '0;
      ch_q         <= 1'b0;
      ldone_q      <= 1'b0;
      shift_q      <= '0;
      l_q          <= '0;
      r_q          <= '0;
      valid_q      <= 1'b0;
`ifdef I2S_RX_FRAME_ERR_EN
      err_q        <= 1'b0;
      last_ch_q    <= 1'b0;
      last_vld_q   <= 1'b0;
`endif
    end else begin
      bclk_sync_q  <= bclk_sync_d;
      lrck_sync_q  <= lrck_sync_d;
      sdata_sync_q <= sdata_sync_d;
      bclk_prev_q  <= bclk_prev_d;
      lrck_prev_q  <= lrck_prev_d;
      cnt_q        <= cnt_d;
      ch_q         <= ch_d;
      ldone_q      <= ldone_d;
      shift_q      <= shift_d;
      l_q          <= l_d;
      r_q          <= r_d;
      valid_q      <= valid_d;
`ifdef I2S_RX_FRAME_ERR_EN
      err_q        <= err_d;
      last_ch_q    <= last_ch_d;
      last_vld_q   <= last_vld_d;
`endif
    end
  end

  assign l_out = l_q;
  assign r_out = r_q;
  assign valid = valid_q;
`ifdef I2S_RX_FRAME_ERR_EN
  assign frame_err = err_q;
`endif

endmodule
